// File: rtl/uart_cmd_parser_if.sv
// Bundle of the byte streams and register port around uart_cmd_parser.
// The parser side is the master; the UART and register file side is the slave.
interface uart_cmd_parser_if;
   logic [7:0] RX_DATA;
   logic       RX_VLD;
   logic       RX_FRAME_ERROR;
   logic       RX_PARITY_ERROR;
   logic [7:0] TX_DATA;
   logic       TX_VLD;
   logic       TX_RDY;
   logic [7:0] REG_ADDR;
   logic [7:0] REG_WDATA;
   logic       REG_WE;
   logic       REG_RE;
   logic [7:0] REG_RDATA;

   modport master (
      input  RX_DATA, RX_VLD, RX_FRAME_ERROR, RX_PARITY_ERROR, TX_RDY, REG_RDATA,
      output TX_DATA, TX_VLD, REG_ADDR, REG_WDATA, REG_WE, REG_RE
   );

   modport slave (
      output RX_DATA, RX_VLD, RX_FRAME_ERROR, RX_PARITY_ERROR, TX_RDY, REG_RDATA,
      input  TX_DATA, TX_VLD, REG_ADDR, REG_WDATA, REG_WE, REG_RE
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// Half-duplex UART register-access parser: assembles A5-framed commands,
// performs one register write/read, and answers with a 5A-framed response.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic                CLK,
   input  logic                RST,
   uart_cmd_parser_if.master   bus,
   output logic                BUSY,
   output logic [7:0]          ERR_CNT
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, READ_WAIT, SEND
   } state_t;

   state_t          state;
   logic [7:0]      cmd_q;
   logic [7:0]      status_q;
   logic [7:0]      rdata_q;
   logic [1:0]      idx;
   logic [TW-1:0]   tmo_cnt;

   logic clean_byte;
   logic bad_byte;
   logic in_get;
   logic tmo_hit;

   assign clean_byte = bus.RX_VLD && !bus.RX_FRAME_ERROR && !bus.RX_PARITY_ERROR;
   assign bad_byte   = bus.RX_VLD && (bus.RX_FRAME_ERROR || bus.RX_PARITY_ERROR);
   assign in_get     = (state == GET_CMD) || (state == GET_ADDR) ||
                       (state == GET_DATA) || (state == GET_CHK);
   // Timeout fires on the TIMEOUT_CYCLES-th consecutive cycle without an accepted byte.
   assign tmo_hit    = in_get && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // NOTE: every register here is assigned with <= so all updates see the
   // pre-edge values; a blocking assignment would leak new values into later lines.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         cmd_q         <= '0;
         status_q      <= '0;
         rdata_q       <= '0;
         idx           <= '0;
         tmo_cnt       <= '0;
         BUSY          <= 1'b0;
         ERR_CNT       <= '0;
         bus.TX_DATA   <= '0;
         bus.TX_VLD    <= 1'b0;
         bus.REG_ADDR  <= '0;
         bus.REG_WDATA <= '0;
         bus.REG_WE    <= 1'b0;
         bus.REG_RE    <= 1'b0;
      end else begin
         bus.REG_WE <= 1'b0;
         bus.REG_RE <= 1'b0;

         case (state)
            IDLE: begin
               if (bad_byte) begin
                  ERR_CNT <= sat_inc(ERR_CNT);
               end else if (clean_byte && bus.RX_DATA == 8'hA5) begin
                  state   <= GET_CMD;
                  BUSY    <= 1'b1;
                  tmo_cnt <= '0;
               end
            end

            GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
               if (tmo_hit || bad_byte) begin
                  state   <= IDLE;
                  BUSY    <= 1'b0;
                  ERR_CNT <= sat_inc(ERR_CNT);
               end else if (clean_byte) begin
                  tmo_cnt <= '0;
                  case (state)
                     GET_CMD:  begin cmd_q         <= bus.RX_DATA; state <= GET_ADDR; end
                     GET_ADDR: begin bus.REG_ADDR  <= bus.RX_DATA; state <= GET_DATA; end
                     GET_DATA: begin bus.REG_WDATA <= bus.RX_DATA; state <= GET_CHK;  end
                     default: begin
                        // Frame is judged as the CHK byte lands so the strobe appears in EXEC.
                        state   <= EXEC;
                        rdata_q <= '0;
                        if (bus.RX_DATA != (cmd_q ^ bus.REG_ADDR ^ bus.REG_WDATA)) begin
                           status_q <= 8'h01;
                        end else if (cmd_q == 8'h01) begin
                           status_q   <= 8'h00;
                           bus.REG_WE <= 1'b1;
                        end else if (cmd_q == 8'h02) begin
                           status_q   <= 8'h00;
                           bus.REG_RE <= 1'b1;
                        end else begin
                           status_q <= 8'h02;
                        end
                     end
                  endcase
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            EXEC: begin
               if (bus.REG_RE) begin
                  state <= READ_WAIT;
               end else begin
                  state       <= SEND;
                  idx         <= '0;
                  bus.TX_VLD  <= 1'b1;
                  bus.TX_DATA <= 8'h5A;
               end
            end

            READ_WAIT: begin
               rdata_q     <= bus.REG_RDATA;
               state       <= SEND;
               idx         <= '0;
               bus.TX_VLD  <= 1'b1;
               bus.TX_DATA <= 8'h5A;
            end

            SEND: begin
               if (bus.TX_VLD && bus.TX_RDY) begin
                  if (idx == 2'd3) begin
                     state      <= IDLE;
                     BUSY       <= 1'b0;
                     bus.TX_VLD <= 1'b0;
                  end else begin
                     idx <= idx + 2'd1;
                     case (idx)
                        2'd0:    bus.TX_DATA <= status_q;
                        2'd1:    bus.TX_DATA <= rdata_q;
                        default: bus.TX_DATA <= status_q ^ rdata_q;
                     endcase
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus queues expected TX bytes and
// register accesses, independent monitors pop and compare as the DUT emits them.
module tb_uart_cmd_parser;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } reg_ev_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic BUSY;
   logic [7:0] ERR_CNT;
   logic [7:0] rd_value = 8'h00;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] tx_q[$];
   reg_ev_t    reg_q[$];

   uart_cmd_parser_if bus();

   uart_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .bus     (bus.master),
      .BUSY    (BUSY),
      .ERR_CNT (ERR_CNT)
   );

   always #5 CLK = ~CLK;

   // Register file stand-in: read data valid exactly the cycle after REG_RE.
   always @(posedge CLK) bus.REG_RDATA <= bus.REG_RE ? rd_value : 8'hEE;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // TX monitor: pops one expected byte per handshake and checks stall stability.
   logic       stalled = 1'b0;
   logic [7:0] held;
   always @(negedge CLK) begin
      if (RST) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("tx_hold_vld", bus.TX_VLD, 1);
            check("tx_hold_data", bus.TX_DATA, held);
         end
         if (bus.TX_VLD && bus.TX_RDY) begin
            if (tx_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL tx_unexpected: got 0x%0h, expected no transfer", bus.TX_DATA);
            end else begin
               check("tx_byte", bus.TX_DATA, tx_q.pop_front());
            end
         end
         stalled = bus.TX_VLD && !bus.TX_RDY;
         held    = bus.TX_DATA;
      end
   end

   // Register-port monitor.
   always @(negedge CLK) begin
      if (!RST && (bus.REG_WE || bus.REG_RE)) begin
         if (reg_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL reg_unexpected: got we=%0b re=%0b, expected no access", bus.REG_WE, bus.REG_RE);
         end else begin
            reg_ev_t ev;
            ev = reg_q.pop_front();
            check("reg_we", bus.REG_WE, ev.we);
            check("reg_re", bus.REG_RE, !ev.we);
            check("reg_addr", bus.REG_ADDR, ev.addr);
            if (ev.we) check("reg_wdata", bus.REG_WDATA, ev.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic fe, input logic pe);
      bus.RX_DATA         = b;
      bus.RX_FRAME_ERROR  = fe;
      bus.RX_PARITY_ERROR = pe;
      bus.RX_VLD          = 1'b1;
      @(posedge CLK); #1;
      bus.RX_VLD          = 1'b0;
      bus.RX_FRAME_ERROR  = 1'b0;
      bus.RX_PARITY_ERROR = 1'b0;
   endtask

   task automatic send_frame(input logic [39:0] f);
      for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b0, 1'b0);
   endtask

   task automatic push_tx(input logic [31:0] r);
      for (int i = 3; i >= 0; i--) tx_q.push_back(r[i*8 +: 8]);
   endtask

   task automatic push_reg(input logic we, input logic [7:0] addr, input logic [7:0] data);
      reg_ev_t ev;
      ev.we = we; ev.addr = addr; ev.data = data;
      reg_q.push_back(ev);
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 60 && BUSY; k++) @(negedge CLK);
      check(name, BUSY, 0);
      check({name, "_txq"}, tx_q.size(), 0);
      check({name, "_regq"}, reg_q.size(), 0);
      @(posedge CLK); #1;
   endtask

   task automatic wait_vld();
      for (int k = 0; k < 20 && !bus.TX_VLD; k++) @(negedge CLK);
      check("tx_vld_rise", bus.TX_VLD, 1);
   endtask

   initial begin
      bus.RX_DATA = '0; bus.RX_VLD = 1'b0;
      bus.RX_FRAME_ERROR = 1'b0; bus.RX_PARITY_ERROR = 1'b0;
      bus.TX_RDY = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_tx_vld", bus.TX_VLD, 0);
      check("rst_tx_data", bus.TX_DATA, 0);
      check("rst_reg_we", bus.REG_WE, 0);
      check("rst_reg_re", bus.REG_RE, 0);
      check("rst_reg_addr", bus.REG_ADDR, 0);
      check("rst_reg_wdata", bus.REG_WDATA, 0);
      check("rst_busy", BUSY, 0);
      check("rst_err_cnt", ERR_CNT, 0);
      @(posedge CLK); #1;

      // Write, with latency CHK@N -> WE@N+1 -> TX_VLD@N+2.
      push_reg(1'b1, 8'h10, 8'h3C);
      push_tx(32'h5A_00_00_00);
      send_frame(40'hA5_01_10_3C_2D);
      @(negedge CLK);
      check("wr_lat_we", bus.REG_WE, 1);
      check("wr_lat_vld0", bus.TX_VLD, 0);
      @(negedge CLK);
      check("wr_lat_vld1", bus.TX_VLD, 1);
      wait_idle("wr_done");
      check("wr_err_cnt", ERR_CNT, 0);
      check("wr_hold_addr", bus.REG_ADDR, 8'h10);
      check("wr_hold_wdata", bus.REG_WDATA, 8'h3C);

      // Read, with latency CHK@N -> RE@N+1 -> TX_VLD@N+3.
      rd_value = 8'h3C;
      push_reg(1'b0, 8'h10, 8'h00);
      push_tx(32'h5A_00_3C_3C);
      send_frame(40'hA5_02_10_00_12);
      @(negedge CLK);
      check("rd_lat_re", bus.REG_RE, 1);
      @(negedge CLK);
      check("rd_lat_vld0", bus.TX_VLD, 0);
      @(negedge CLK);
      check("rd_lat_vld1", bus.TX_VLD, 1);
      wait_idle("rd_done");

      // Checksum error, then unknown command.
      push_tx(32'h5A_01_00_01);
      send_frame(40'hA5_01_10_3C_00);
      wait_idle("badchk_done");
      push_tx(32'h5A_02_00_02);
      send_frame(40'hA5_07_00_00_07);
      wait_idle("badcmd_done");

      // Garbage then parity-error abort mid-frame.
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      send_byte(8'hA5, 1'b0, 1'b0);
      send_byte(8'h01, 1'b0, 1'b1);
      @(negedge CLK);
      check("abort_err_cnt", ERR_CNT, 1);
      check("abort_busy", BUSY, 0);
      @(posedge CLK); #1;
      push_reg(1'b1, 8'h20, 8'h55);
      push_tx(32'h5A_00_00_00);
      send_frame(40'hA5_01_20_55_74);
      wait_idle("post_abort_done");

      // Framing error in IDLE also counts.
      send_byte(8'hA5, 1'b1, 1'b0);
      @(negedge CLK);
      check("idle_fe_err_cnt", ERR_CNT, 2);
      check("idle_fe_busy", BUSY, 0);
      @(posedge CLK); #1;

      // Inter-byte timeout after A5 01.
      send_byte(8'hA5, 1'b0, 1'b0);
      send_byte(8'h01, 1'b0, 1'b0);
      repeat (95) @(negedge CLK);
      check("tmo_busy_before", BUSY, 1);
      repeat (7) @(negedge CLK);
      check("tmo_busy_after", BUSY, 0);
      check("tmo_err_cnt", ERR_CNT, 3);
      @(posedge CLK); #1;
      push_reg(1'b1, 8'h30, 8'h99);
      push_tx(32'h5A_00_00_00);
      send_frame(40'hA5_01_30_99_A8);
      wait_idle("post_tmo_done");

      // Backpressure on a read response.
      rd_value = 8'hC3;
      bus.TX_RDY = 1'b0;
      push_reg(1'b0, 8'h10, 8'h00);
      push_tx(32'h5A_00_C3_C3);
      send_frame(40'hA5_02_10_00_12);
      wait_vld();
      @(posedge CLK); #1;
      repeat (6) begin @(posedge CLK); #1; end
      for (int i = 0; i < 8; i++) begin
         bus.TX_RDY = (i % 2 == 0);
         @(posedge CLK); #1;
      end
      bus.TX_RDY = 1'b1;
      wait_idle("bp_done");

      // ERR_CNT saturation.
      for (int i = 0; i < 260; i++) send_byte(8'h00, 1'b0, 1'b1);
      @(negedge CLK);
      check("err_cnt_sat", ERR_CNT, 255);
      @(posedge CLK); #1;

      // Reset while a response is stalled drops it.
      bus.TX_RDY = 1'b0;
      push_reg(1'b1, 8'h40, 8'h11);
      send_frame(40'hA5_01_40_11_50);
      wait_vld();
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      tx_q.delete();
      @(negedge CLK);
      check("midrst_tx_vld", bus.TX_VLD, 0);
      check("midrst_busy", BUSY, 0);
      check("midrst_err_cnt", ERR_CNT, 0);
      bus.TX_RDY = 1'b1;
      repeat (5) @(negedge CLK);
      check("end_txq", tx_q.size(), 0);
      check("end_regq", reg_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser that sits directly downstream of the UART receiver and upstream of the UART transmitter. It assembles 5-byte register-access frames from the received byte stream, validates each frame, and issues one register write or read on a simple internal register port. It then returns a 4-byte response frame through the transmitter's valid/ready handshake. The block is half-duplex: it accepts one command, answers it, then listens again.

## Interface
Parameters:
- TIMEOUT_CYCLES, 500000: max CLK cycles between bytes of a frame before the partial frame is abandoned (≥2).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- RX_DATA  in  8  received byte; qualified by RX_VLD.
- RX_VLD  in  1  one-cycle strobe per received byte; no backpressure.
- RX_FRAME_ERROR  in  1  stop-bit error on the current byte; valid with RX_VLD.
- RX_PARITY_ERROR  in  1  parity error on the current byte; valid with RX_VLD.
- TX_DATA  out  8  response byte to the transmitter.
- TX_VLD  out  1  TX_DATA valid.
- TX_RDY  in  1  transmitter can accept; transfer occurs when TX_VLD && TX_RDY.
- REG_ADDR  out  8  register address.
- REG_WDATA  out  8  write data.
- REG_WE  out  1  one-cycle write strobe.
- REG_RE  out  1  one-cycle read strobe.
- REG_RDATA  in  8  read data; valid the cycle after REG_RE.
- BUSY  out  1  high whenever the state is not IDLE.
- ERR_CNT  out  8  count of aborted frames; saturates at 255.

## Operation
- Command frame: 0xA5, CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA.
  - CMD 0x01 = write.
  - CMD 0x02 = read; its DATA byte is don't-care but is still included in CHK.
- Response frame: 0x5A, STATUS, RDATA, RCHK, where RCHK = STATUS^RDATA.
  - STATUS 0x00 = ok, 0x01 = checksum mismatch, 0x02 = unknown CMD.
  - RDATA is 0x00 for writes and for any error.
- States: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, READ_WAIT, SEND.
- IDLE:
  - A clean RX byte equal to 0xA5 → GET_CMD.
  - Any other clean byte is ignored; it is not counted as an error.
- GET_CMD → GET_ADDR → GET_DATA → GET_CHK: each state latches one clean byte, then advances.
- GET_CHK, on a clean byte → EXEC.
- EXEC (one cycle) evaluates the frame; checksum is checked before CMD:
  - Checksum bad → STATUS 0x01, no register access, → SEND.
  - Checksum good, CMD 0x01 → REG_WE=1, → SEND with STATUS 0x00.
  - Checksum good, CMD 0x02 → REG_RE=1, → READ_WAIT.
  - Checksum good, any other CMD → STATUS 0x02, no access, → SEND.
- READ_WAIT (one cycle): capture REG_RDATA, → SEND.
- SEND:
  - Present the response bytes in order.
  - TX_DATA is held stable and TX_VLD held high until TX_VLD && TX_RDY; the byte index then increments.
  - After the 4th transfer → IDLE.
- Error byte (RX_VLD with either error flag set) in IDLE or any GET_* state: discard the byte and any partial frame, ERR_CNT++, → IDLE.
- Timeout in GET_*:
  - The timeout counter clears on entering GET_CMD and on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: → IDLE, ERR_CNT++.
  - A byte arriving in the same cycle as the timeout is dropped.
- RX bytes arriving in EXEC, READ_WAIT or SEND are discarded without counting.
- REG_ADDR and REG_WDATA hold the last latched ADDR and DATA. They are stable from EXEC until the next frame.
- ERR_CNT holds at 255.

## Timing
- Reset (RST=1 at a CLK edge) forces:
  - state IDLE; all counters 0;
  - TX_VLD, TX_DATA, REG_WE, REG_RE, REG_ADDR, REG_WDATA, BUSY and ERR_CNT = 0.
- Reset mid-SEND drops the rest of the response immediately.
- All outputs are registered.
- Write latency: CHK byte accepted at cycle N → REG_WE high at N+1 → TX_VLD high at N+2.
- Read latency: CHK byte at N → REG_RE at N+1 → REG_RDATA sampled at N+2 → TX_VLD at N+3.
- Back-to-back TX: with TX_RDY held high, one byte is transferred per cycle, so 4 cycles per response.
- BUSY rises the cycle after 0xA5 is accepted and falls the cycle after the last TX transfer, abort, or timeout.

## Test plan
- Write: RX A5 01 10 3C 2D → one REG_WE pulse with ADDR=0x10, WDATA=0x3C; TX 5A 00 00 00; ERR_CNT=0.
- Read: RX A5 02 10 00 12 with REG_RDATA=0x3C → one REG_RE pulse with ADDR=0x10; TX 5A 00 3C 3C.
- Bad checksum A5 01 10 3C 00 → no REG_WE/REG_RE; TX 5A 01 00 01. Bad CMD A5 07 00 00 07 → TX 5A 02 00 02.
- Garbage/abort: RX 11 22 A5 01 with RX_PARITY_ERROR set on 0x01 → ERR_CNT=1, no TX. A following valid write frame completes normally.
- Timeout (TIMEOUT_CYCLES=100): RX A5 01, then silence for 100 cycles → BUSY falls, ERR_CNT increments, no TX. Full frame afterwards is accepted.
- Backpressure: read frame with TX_RDY low for 7 cycles, then toggled 1/0 → TX_DATA stable while stalled; exactly 4 transfers, in order 5A 00 xx xx.
